// File: rtl/telemetry_uart_pkg.sv
// Shared constants, types and helpers for the telemetry UART framer.
//   SYNC0/SYNC1       frame sync bytes
//   FRAME_LEN         bytes per frame
//   BITS_PER_BYTE     start + 8 data + stop
//   STAT_*            bit positions inside the status byte
//   snapshot_t        values latched when a trigger is accepted
package telemetry_uart_pkg;

  localparam logic [7:0] SYNC0 = 8'hA5;
  localparam logic [7:0] SYNC1 = 8'h5A;

  localparam int FRAME_LEN     = 13;
  localparam int BITS_PER_BYTE = 10;

  localparam int STAT_LOCKED   = 7;
  localparam int STAT_OVERRUN  = 6;
  localparam int STAT_MAGPHASE = 5;
  localparam int STAT_GAIN_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } tx_state_t;

  typedef struct packed {
    logic [7:0]  seq;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] mag;
    logic [15:0] ang;
    logic [7:0]  status;
    logic [7:0]  csum;
  } snapshot_t;

  function automatic logic [7:0] make_status(input logic       locked,
                                             input logic       overrun,
                                             input logic       ismagphase,
                                             input logic [1:0] gain);
    logic [7:0] s;
    s = '0;
    s[STAT_LOCKED]          = locked;
    s[STAT_OVERRUN]         = overrun;
    s[STAT_MAGPHASE]        = ismagphase;
    s[STAT_GAIN_LSB +: 2]   = gain;
    return s;
  endfunction

  // Modulo-256 sum of every payload byte between the sync word and the checksum.
  function automatic logic [7:0] frame_csum(input logic [7:0]  seq,
                                            input logic [15:0] x,
                                            input logic [15:0] y,
                                            input logic [15:0] mag,
                                            input logic [15:0] ang,
                                            input logic [7:0]  status);
    logic [7:0] sum;
    sum = seq + x[15:8] + x[7:0] + y[15:8] + y[7:0]
        + mag[15:8] + mag[7:0] + ang[15:8] + ang[7:0] + status;
    return sum;
  endfunction

  function automatic logic [7:0] frame_byte(input snapshot_t  s,
                                            input logic [3:0] idx);
    logic [7:0] b;
    case (idx)
      4'd0:    b = SYNC0;
      4'd1:    b = SYNC1;
      4'd2:    b = s.seq;
      4'd3:    b = s.x[15:8];
      4'd4:    b = s.x[7:0];
      4'd5:    b = s.y[15:8];
      4'd6:    b = s.y[7:0];
      4'd7:    b = s.mag[15:8];
      4'd8:    b = s.mag[7:0];
      4'd9:    b = s.ang[15:8];
      4'd10:   b = s.ang[7:0];
      4'd11:   b = s.status;
      4'd12:   b = s.csum;
      default: b = SYNC0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/telemetry_uart_tx.sv
// uart_tx_byte: 8N1 serialiser for one byte.
//   CLK36   system clock
//   rst_n   async active-low reset (line returns to idle high at once)
//   load    start a byte; tx drops to the start bit on the next cycle
//   data    byte to send, LSB first
//   tx      serial line, idles high
//   ready   high during the final cycle of the stop bit; a load in that
//           cycle chains the next byte with no idle gap
module uart_tx_byte
  import telemetry_uart_pkg::*;
#(
  parameter int BAUD_DIV = 39
) (
  input  logic       CLK36,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_DIV - 1);
  localparam logic [3:0]  FIRST_LEFT  = 4'(BITS_PER_BYTE - 1);

  logic [15:0] baud_cnt;
  logic [3:0]  bits_left;
  logic [8:0]  shreg;
  logic        active;
  logic        baud_tc;

  assign baud_tc = (baud_cnt == 16'd0);
  assign ready   = active && baud_tc && (bits_left == 4'd0);

  // bits_left counts the bit periods still to follow the one on the line;
  // the stop bit is pre-loaded as shreg[8] so it falls out of the shifter.
  always_ff @(posedge CLK36 or negedge rst_n) begin
    if (!rst_n) begin
      tx        <= 1'b1;
      active    <= 1'b0;
      baud_cnt  <= 16'd0;
      bits_left <= 4'd0;
      shreg     <= '1;
    end else if (load) begin
      tx        <= 1'b0;
      active    <= 1'b1;
      shreg     <= {1'b1, data};
      bits_left <= FIRST_LEFT;
      baud_cnt  <= BAUD_RELOAD;
    end else if (active) begin
      if (!baud_tc) begin
        baud_cnt <= baud_cnt - 16'd1;
      end else if (bits_left == 4'd0) begin
        active <= 1'b0;
        tx     <= 1'b1;
      end else begin
        tx        <= shreg[0];
        shreg     <= {1'b1, shreg[8:1]};
        bits_left <= bits_left - 4'd1;
        baud_cnt  <= BAUD_RELOAD;
      end
    end
  end

endmodule

// File: rtl/telemetry_uart.sv
// telemetry_uart: snapshots lock-in results on a trigger and streams them as
// one 13-byte checksummed 8N1 frame.
//   CLK36       system clock
//   rst_n       async active-low reset
//   en          enables trigger acceptance
//   trig        1-cycle frame request
//   x, y        X/Y results (upper 16 bits)
//   mag, ang    magnitude / angle
//   locked      PLL lock indicator        (status bit 7)
//   ismagphase  output-mode setting       (status bit 5)
//   gain        PGA gain                  (status bits 1:0)
//   tx          UART line, idles high
//   busy        frame in flight
//   frame_done  1-cycle pulse after the last stop bit
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | line idle, waiting for trig && en
// ST_SEND | streaming byte byte_idx of the frame
// ST_DONE | one cycle after the last stop bit; a new trig is accepted
module telemetry_uart
  import telemetry_uart_pkg::*;
#(
  parameter int BAUD_DIV = 39
) (
  input  logic        CLK36,
  input  logic        rst_n,
  input  logic        en,
  input  logic        trig,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] mag,
  input  logic [15:0] ang,
  input  logic        locked,
  input  logic        ismagphase,
  input  logic [1:0]  gain,
  output logic        tx,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  tx_state_t  state, state_nxt;
  logic [3:0] byte_idx, byte_idx_nxt;
  logic [7:0] seq;
  logic       overrun;
  snapshot_t  snap, snap_now;
  logic       accept, drop;
  logic       load, ready, frame_end;
  logic [7:0] load_data;
  logic [7:0] status_now;

  // DONE counts as not busy, so a trigger there starts the next frame; the
  // last stop-bit cycle is still SEND, so a trigger there is a drop.
  assign accept = trig && en && (state != ST_SEND);
  assign drop   = trig && en && (state == ST_SEND);

  assign busy       = (state == ST_SEND);
  assign frame_done = (state == ST_DONE);

  assign status_now = make_status(locked, overrun, ismagphase, gain);

  always_comb begin
    snap_now        = '0;
    snap_now.seq    = seq;
    snap_now.x      = x;
    snap_now.y      = y;
    snap_now.mag    = mag;
    snap_now.ang    = ang;
    snap_now.status = status_now;
    snap_now.csum   = frame_csum(seq, x, y, mag, ang, status_now);
  end

  always_ff @(posedge CLK36 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      byte_idx <= 4'd0;
    end else begin
      state    <= state_nxt;
      byte_idx <= byte_idx_nxt;
    end
  end

  // The first sync byte is a constant, so it can be loaded on the accept
  // edge itself, in parallel with the snapshot.
  always_comb begin
    state_nxt    = state;
    byte_idx_nxt = byte_idx;
    load         = 1'b0;
    load_data    = SYNC0;
    frame_end    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_nxt    = ST_SEND;
          byte_idx_nxt = 4'd0;
          load         = 1'b1;
          load_data    = SYNC0;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (ready) begin
          if (byte_idx == LAST_IDX) begin
            state_nxt = ST_DONE;
            frame_end = 1'b1;
          end else begin
            load         = 1'b1;
            byte_idx_nxt = byte_idx + 4'd1;
            load_data    = frame_byte(snap, byte_idx + 4'd1);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK36 or negedge rst_n) begin
    if (!rst_n) begin
      snap    <= '0;
      seq     <= 8'd0;
      overrun <= 1'b0;
    end else begin
      if (accept) begin
        snap <= snap_now;
      end
      if (frame_end) begin
        seq <= seq + 8'd1;
      end
      if (accept) begin
        overrun <= 1'b0;
      end else if (drop) begin
        overrun <= 1'b1;
      end
    end
  end

  uart_tx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tx (
    .CLK36 (CLK36),
    .rst_n (rst_n),
    .load  (load),
    .data  (load_data),
    .tx    (tx),
    .ready (ready)
  );

endmodule

// File: tb/tb_telemetry_uart.sv
module tb_telemetry_uart;

  typedef logic [12:0][7:0] frame_t;

  logic        CLK36 = 1'b0;
  logic        rst_n, en, trig;
  logic [15:0] x, y, mag, ang;
  logic        locked, ismagphase;
  logic [1:0]  gain;

  logic [1:0]  sel;
  int          cur_bd;

  logic tx_a, busy_a, fd_a;
  logic tx_b, busy_b, fd_b;
  logic tx_c, busy_c, fd_c;
  logic trig_a, trig_b, trig_c;
  logic tx, busy, frame_done;

  int errors = 0;
  int checks = 0;

  logic [7:0] rx_q[$];
  int         frame_errs = 0;

  int m_seq;
  bit m_ovr;

  always #5 CLK36 = ~CLK36;

  assign trig_a = trig && (sel == 2'd0);
  assign trig_b = trig && (sel == 2'd1);
  assign trig_c = trig && (sel == 2'd2);

  assign tx         = (sel == 2'd0) ? tx_a   : (sel == 2'd1) ? tx_b   : tx_c;
  assign busy       = (sel == 2'd0) ? busy_a : (sel == 2'd1) ? busy_b : busy_c;
  assign frame_done = (sel == 2'd0) ? fd_a   : (sel == 2'd1) ? fd_b   : fd_c;

  telemetry_uart #(.BAUD_DIV(4)) dut4 (
    .CLK36(CLK36), .rst_n(rst_n), .en(en), .trig(trig_a),
    .x(x), .y(y), .mag(mag), .ang(ang), .locked(locked),
    .ismagphase(ismagphase), .gain(gain),
    .tx(tx_a), .busy(busy_a), .frame_done(fd_a));

  telemetry_uart #(.BAUD_DIV(2)) dut2 (
    .CLK36(CLK36), .rst_n(rst_n), .en(en), .trig(trig_b),
    .x(x), .y(y), .mag(mag), .ang(ang), .locked(locked),
    .ismagphase(ismagphase), .gain(gain),
    .tx(tx_b), .busy(busy_b), .frame_done(fd_b));

  telemetry_uart #(.BAUD_DIV(39)) dut39 (
    .CLK36(CLK36), .rst_n(rst_n), .en(en), .trig(trig_c),
    .x(x), .y(y), .mag(mag), .ang(ang), .locked(locked),
    .ismagphase(ismagphase), .gain(gain),
    .tx(tx_c), .busy(busy_c), .frame_done(fd_c));

  // UART receiver on the selected line, sampling on falling clock edges.
  int         mon_cnt;
  int         mon_bit;
  bit         mon_act = 1'b0;
  logic [7:0] mon_sh;

  always @(negedge CLK36) begin
    if (!rst_n) begin
      mon_act = 1'b0;
    end else if (!mon_act) begin
      if (tx === 1'b0) begin
        mon_act = 1'b1;
        mon_cnt = 0;
        mon_bit = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == cur_bd) begin
        mon_cnt = 0;
        mon_bit++;
        if (mon_bit <= 8) begin
          mon_sh[mon_bit-1] = tx;
        end else begin
          if (tx !== 1'b1) frame_errs++;
          else rx_q.push_back(mon_sh);
          mon_act = 1'b0;
        end
      end
    end
  end

  // Reference frame straight from the packet layout.
  function automatic frame_t build_frame(input int sq, input logic [15:0] fx, fy, fm, fa,
                                         input bit lk, ov, mp, input logic [1:0] g);
    frame_t f;
    int     sum;
    f[0]  = 8'hA5;
    f[1]  = 8'h5A;
    f[2]  = 8'(sq);
    f[3]  = fx[15:8];
    f[4]  = fx[7:0];
    f[5]  = fy[15:8];
    f[6]  = fy[7:0];
    f[7]  = fm[15:8];
    f[8]  = fm[7:0];
    f[9]  = fa[15:8];
    f[10] = fa[7:0];
    f[11] = {lk, ov, mp, 3'b000, g};
    sum = 0;
    for (int i = 2; i <= 11; i++) sum += int'(f[i]);
    f[12] = 8'(sum % 256);
    return f;
  endfunction

  task automatic rand_inputs();
    x          = 16'($urandom);
    y          = 16'($urandom);
    mag        = 16'($urandom);
    ang        = 16'($urandom);
    locked     = 1'($urandom_range(0, 1));
    ismagphase = 1'($urandom_range(0, 1));
    gain       = 2'($urandom_range(0, 3));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    trig  = 1'b0;
    en    = 1'b1;
    repeat (3) @(negedge CLK36);
    rst_n = 1'b1;
    m_seq = 0;
    m_ovr = 1'b0;
    rx_q.delete();
    @(negedge CLK36);
  endtask

  task automatic fire(output frame_t ex);
    ex   = build_frame(m_seq, x, y, mag, ang, locked, m_ovr, ismagphase, gain);
    en   = 1'b1;
    trig = 1'b1;
    @(negedge CLK36);
    trig  = 1'b0;
    m_seq = (m_seq + 1) % 256;
    m_ovr = 1'b0;
    checks++;
    if (busy !== 1'b1 || tx !== 1'b0) begin
      errors++;
      $display("FAIL accept busy=%b tx=%b want busy=1 tx=0", busy, tx);
    end
  endtask

  // Runs the in-flight frame to its DONE cycle, optionally injecting a
  // mid-frame trigger or holding trig from the last stop-bit cycle onward.
  task automatic run_frame(input int drop_at, input bit drop_en, input bit hold_last,
                           input bit toggle, output int busy_cnt, output bit timed_out);
    busy_cnt  = 0;
    timed_out = 1'b1;
    for (int c = 0; c < 130*cur_bd + 50; c++) begin
      if (frame_done === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      if (busy === 1'b1) busy_cnt++;
      trig = 1'b0;
      en   = 1'b1;
      if (busy_cnt == drop_at) begin
        trig = 1'b1;
        en   = drop_en;
        if (drop_en) m_ovr = 1'b1;
      end
      if (hold_last && busy_cnt == 130*cur_bd) begin
        trig  = 1'b1;
        m_ovr = 1'b1;
      end
      if (toggle) rand_inputs();
      @(negedge CLK36);
    end
  endtask

  task automatic grab_frame(output frame_t got, output int n);
    n   = rx_q.size();
    got = 'x;
    for (int i = 0; i < 13 && rx_q.size() > 0; i++) got[i] = rx_q.pop_front();
    rx_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 200; c++) begin
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL idle cyc%0d tx=%b busy=%b done=%b want 1 0 0", c, tx, busy, frame_done);
      end
      @(negedge CLK36);
    end
  endtask

  task automatic test_single_frame();
    frame_t ex, got, lit;
    int     bc, n;
    bit     to;
    do_reset();
    x = 16'h1234; y = 16'hABCD; mag = 16'h00FF; ang = 16'h8000;
    locked = 1'b1; gain = 2'd2; ismagphase = 1'b0;
    lit = {8'hBF, 8'h82, 8'h00, 8'h80, 8'hFF, 8'h00, 8'hCD, 8'hAB, 8'h34, 8'h12, 8'h00, 8'h5A, 8'hA5};
    fire(ex);
    run_frame(-1, 1'b1, 1'b0, 1'b0, bc, to);
    checks++;
    if (to) begin errors++; $display("FAIL single_timeout no frame_done"); end
    checks++;
    if (bc != 520) begin errors++; $display("FAIL single_busy_len got %0d want 520", bc); end
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL single_done_cycle busy=%b tx=%b want 0 1", busy, tx);
    end
    grab_frame(got, n);
    checks++;
    if (n != 13 || got !== lit) begin
      errors++;
      $display("FAIL single_frame n=%0d got %h want %h", n, got, lit);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK36);
      checks++;
      if (frame_done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL single_after cyc%0d done=%b busy=%b want 0 0", c, frame_done, busy);
      end
    end
  endtask

  task automatic test_overrun();
    frame_t ex, got;
    int     bc, n;
    bit     to;
    do_reset();
    for (int f = 0; f < 3; f++) begin
      rand_inputs();
      fire(ex);
      run_frame((f == 0) ? 200 : -1, 1'b1, 1'b0, 1'b0, bc, to);
      grab_frame(got, n);
      checks++;
      if (to || n != 13 || got !== ex) begin
        errors++;
        $display("FAIL overrun_frame%0d to=%b n=%0d got %h want %h", f, to, n, got, ex);
      end
      if (f > 0) begin
        checks++;
        if (got[11][6] !== (f == 1) || got[2] !== 8'(f)) begin
          errors++;
          $display("FAIL overrun_status%0d ovr=%b seq=%02h want ovr=%0d seq=%02h",
                   f, got[11][6], got[2], (f == 1), f);
        end
      end
    end
  endtask

  task automatic test_toggle();
    frame_t ex, got;
    int     bc, n;
    bit     to;
    do_reset();
    rand_inputs();
    fire(ex);
    run_frame(-1, 1'b1, 1'b0, 1'b1, bc, to);
    grab_frame(got, n);
    checks++;
    if (to || n != 13 || got !== ex) begin
      errors++;
      $display("FAIL toggle_frame to=%b n=%0d got %h want %h", to, n, got, ex);
    end
  endtask

  task automatic test_back_to_back();
    frame_t ex1, ex2, got;
    int     bc, n;
    bit     to;
    do_reset();
    rand_inputs();
    fire(ex1);
    run_frame(-1, 1'b1, 1'b1, 1'b0, bc, to);
    checks++;
    if (to || bc != 520 || busy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL b2b_end to=%b len=%0d busy=%b tx=%b want 0 520 0 1", to, bc, busy, tx);
    end
    grab_frame(got, n);
    checks++;
    if (n != 13 || got !== ex1) begin
      errors++;
      $display("FAIL b2b_frame1 n=%0d got %h want %h", n, got, ex1);
    end
    rand_inputs();
    fire(ex2);
    run_frame(-1, 1'b1, 1'b0, 1'b0, bc, to);
    grab_frame(got, n);
    checks++;
    if (to || n != 13 || got !== ex2 || got[11][6] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_frame2 to=%b n=%0d got %h want %h", to, n, got, ex2);
    end
  endtask

  task automatic test_seq_wrap();
    frame_t     ex, got;
    int         bc, n, sum;
    bit         to;
    logic [7:0] want_seq;
    sel = 2'd1;
    cur_bd = 2;
    do_reset();
    for (int f = 0; f < 257; f++) begin
      rand_inputs();
      fire(ex);
      run_frame(-1, 1'b1, 1'b0, 1'b0, bc, to);
      grab_frame(got, n);
      want_seq = 8'(f);
      sum = 0;
      for (int i = 2; i <= 11; i++) sum += int'(got[i]);
      checks++;
      if (to || bc != 260 || n != 13 || got !== ex || got[2] !== want_seq || got[12] !== 8'(sum)) begin
        errors++;
        $display("FAIL wrap_frame%0d to=%b len=%0d n=%0d got %h want %h", f, to, bc, n, got, ex);
      end
    end
    sel = 2'd0;
    cur_bd = 4;
  endtask

  task automatic test_reset_enable();
    frame_t ex, got;
    int     bc, n;
    bit     to;
    do_reset();
    rand_inputs();
    fire(ex);
    repeat (30) @(negedge CLK36);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset tx=%b busy=%b done=%b want 1 0 0", tx, busy, frame_done);
    end
    repeat (2) @(negedge CLK36);
    rst_n = 1'b1;
    m_seq = 0;
    m_ovr = 1'b0;
    rx_q.delete();
    @(negedge CLK36);
    en   = 1'b0;
    trig = 1'b1;
    @(negedge CLK36);
    trig = 1'b0;
    en   = 1'b1;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (busy !== 1'b0 || tx !== 1'b1) begin
        errors++;
        $display("FAIL en_low_idle cyc%0d busy=%b tx=%b want 0 1", c, busy, tx);
      end
      @(negedge CLK36);
    end
    for (int f = 0; f < 2; f++) begin
      rand_inputs();
      fire(ex);
      run_frame((f == 0) ? 100 : -1, 1'b0, 1'b0, 1'b0, bc, to);
      grab_frame(got, n);
      checks++;
      if (to || n != 13 || got !== ex || got[2] !== 8'(f) || got[11][6] !== 1'b0) begin
        errors++;
        $display("FAIL rst_en_frame%0d to=%b n=%0d got %h want %h", f, to, n, got, ex);
      end
    end
  endtask

  task automatic test_baud39();
    frame_t ex, got;
    int     bc, n, low;
    bit     to;
    sel = 2'd2;
    cur_bd = 39;
    do_reset();
    rand_inputs();
    fire(ex);
    low = 0;
    for (int c = 0; c < 100 && tx === 1'b0; c++) begin
      low++;
      @(negedge CLK36);
    end
    run_frame(-1, 1'b1, 1'b0, 1'b0, bc, to);
    checks++;
    if (low != 39) begin errors++; $display("FAIL baud39_bit got %0d want 39", low); end
    checks++;
    if (to || low + bc != 5070) begin
      errors++;
      $display("FAIL baud39_len to=%b got %0d want 5070", to, low + bc);
    end
    grab_frame(got, n);
    checks++;
    if (n != 13 || got !== ex) begin
      errors++;
      $display("FAIL baud39_frame n=%0d got %h want %h", n, got, ex);
    end
    sel = 2'd0;
    cur_bd = 4;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; trig = 1'b0;
    x = '0; y = '0; mag = '0; ang = '0;
    locked = 1'b0; ismagphase = 1'b0; gain = 2'd0;
    sel = 2'd0;
    cur_bd = 4;
    m_seq = 0;
    m_ovr = 1'b0;
    @(negedge CLK36);
    test_reset();
    test_single_frame();
    test_overrun();
    test_toggle();
    test_back_to_back();
    test_reset_enable();
    test_baud39();
    test_seq_wrap();
    checks++;
    if (frame_errs != 0) begin
      errors++;
      $display("FAIL stop_bits got %0d framing errors want 0", frame_errs);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
